alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, operand/result width in bits; it SHALL match the shared ALU width.
REQ-002 Port clk, input, 1, single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1, asynchronous active-low reset.
REQ-004 Ports req0 / req1, input, 1 each, operation request from requester 0 / 1.
REQ-005 Ports a0, b0 / a1, b1, input, DATA_W each, operands of requester 0 / 1.
REQ-006 Ports sel0 / sel1, input, 2 each, ALU opcode: 00 add, 01 sub, 10 NOT a, 11 add.
REQ-007 Ports alu_a, alu_b, output, DATA_W each, registered operands driven to the shared ALU.
REQ-008 Port alu_sel, output, 2, registered opcode driven to the shared ALU.
REQ-009 Ports alu_result, input, DATA_W, and alu_zero, input, 1, combinational ALU outputs.
REQ-010 Port result, output, DATA_W, registered captured ALU result.
REQ-011 Port zero, output, 1, registered captured ALU zero flag.
REQ-012 Ports done0 / done1, output, 1 each, one-cycle completion pulse to requester 0 / 1.
REQ-013 Port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, DONE; transitions IDLE->EXEC on any req, EXEC->DONE always, DONE->IDLE always.
REQ-015 In IDLE with at least one req high, the winner's a, b and sel SHALL be latched into alu_a, alu_b and alu_sel, and the winner's index SHALL be recorded.
REQ-016 Round-robin: with both reqs high, the requester not granted most recently SHALL win; with one req high, that requester SHALL win.
REQ-017 The last-grant register SHALL be 1 after reset, so requester 0 wins the first tie.
REQ-018 In EXEC, alu_result and alu_zero SHALL be captured into result and zero at the closing edge.
REQ-019 In DONE, only the granted requester's done SHALL be high, for exactly one cycle; result and zero SHALL be valid in that cycle and hold until the next capture.
REQ-020 Latency SHALL be fixed: req sampled in IDLE at cycle t gives done in cycle t+2; one operation completes every 3 cycles.
REQ-021 Requests SHALL be sampled only in IDLE; req, a, b and sel changes in EXEC or DONE SHALL be ignored.
REQ-022 A req still high when the FSM returns to IDLE SHALL be treated as a new request; requesters drop req in the cycle after done.
REQ-023 Opcode 11 SHALL pass to alu_sel unchanged; arithmetic SHALL wrap modulo 2^DATA_W inside the ALU, with no carry or overflow output.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, alu_a, alu_b, alu_sel, result, zero, done0, done1 and busy to 0, and last-grant to 1.
REQ-025 Reset during EXEC or DONE SHALL abort the operation with no done pulse; the first edge after rst_n rises SHALL arbitrate normally.

Configuration
REQ-026 Macro ALU_ARB_PRIO_EN defined: fixed priority, req0 SHALL always win over req1 and last-grant is unused.
REQ-027 Macro ALU_ARB_PRIO_EN undefined: round-robin per REQ-016/REQ-017.

Verification
REQ-028 Reset: rst_n low mid-stream -> all outputs 0 asynchronously, busy 0.
REQ-029 req0 only, a0=8'h05, b0=8'h03, sel0=00 -> done0 pulses 2 cycles later, result=8'h08, zero=0, done1 stays 0.
REQ-030 Overflow: req1 only, a1=8'hFF, b1=8'h01, sel1=00 -> done1, result=8'h00, zero=1.
REQ-031 Round-robin, both reqs held, req0 8'h10-8'h10 sel 01, req1 ~8'hF0 sel 10 -> done0 (result 8'h00, zero=1), then done1 (result 8'h0F, zero=0), then done0; grants alternate.
REQ-032 ALU_ARB_PRIO_EN defined, both reqs held for 4 operations -> four done0 pulses, done1 never asserted.
REQ-033 rst_n pulsed low during EXEC -> no done pulse; a fresh req0 after reset completes with correct result 2 cycles after sampling.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: IDLE -> EXEC -> DONE, done two cycles after grant.
// Round-robin arbitration by default; define ALU_ARB_PRIO_EN for fixed priority (req0 always wins).
module alu_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  input  logic [1:0]        sel0,
  input  logic [1:0]        sel1,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [1:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              done0,
  output logic              done1,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t state;
  logic   grant;
  logic   win_vld;
  logic   winner;

`ifndef ALU_ARB_PRIO_EN
  logic   last_grant;
`endif

  always_comb begin
    win_vld = req0 | req1;
`ifdef ALU_ARB_PRIO_EN
    winner  = ~req0;
`else
    // On a tie the requester not served most recently wins.
    winner  = (req0 & req1) ? ~last_grant : req1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= '0;
      result     <= '0;
      zero       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      busy       <= 1'b0;
      grant      <= 1'b0;
`ifndef ALU_ARB_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          if (win_vld) begin
            alu_a      <= winner ? a1 : a0;
            alu_b      <= winner ? b1 : b0;
            alu_sel    <= winner ? sel1 : sel0;
            grant      <= winner;
`ifndef ALU_ARB_PRIO_EN
            last_grant <= winner;
`endif
            busy       <= 1'b1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          result <= alu_result;
          zero   <= alu_zero;
          done0  <= ~grant;
          done1  <= grant;
          state  <= DONE;
        end
        DONE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural shared ALU attached.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [7:0] a0, b0, a1, b1;
  logic [1:0] sel0, sel1;
  logic [7:0] alu_a, alu_b, alu_result, result;
  logic [1:0] alu_sel;
  logic       alu_zero, zero, done0, done1, busy;

  int vectors = 0;
  int miscompares = 0;
  logic exp_last = 1'b1;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .sel0(sel0), .sel1(sel1),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .result(result), .zero(zero),
    .done0(done0), .done1(done1), .busy(busy)
  );

  // Shared ALU: 00 add, 01 sub, 10 NOT a, 11 add; wraps modulo 256.
  always_comb begin
    case (alu_sel)
      2'b01:   alu_result = alu_a - alu_b;
      2'b10:   alu_result = ~alu_a;
      default: alu_result = alu_a + alu_b;
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 0; req1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0; sel0 = 0; sel1 = 0;
    tick(); tick();
    vectors++;
    if ({alu_a, alu_b, alu_sel, result, zero, done0, done1, busy} !== 29'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got %h want 0", {alu_a, alu_b, alu_sel, result, zero, done0, done1, busy});
    end
    rst_n = 1'b1;
    exp_last = 1'b1;
  endtask

  // One operation from a single requester; inputs change during EXEC must be ignored.
  task automatic test_single(input logic who, input logic [7:0] a, input logic [7:0] b,
                             input logic [1:0] sel, input logic [7:0] exp_r, input logic exp_z);
    if (who) begin req1 = 1; a1 = a; b1 = b; sel1 = sel; end
    else     begin req0 = 1; a0 = a; b0 = b; sel0 = sel; end
    tick();
    req0 = 0; req1 = 0; a0 = 8'hAA; b0 = 8'h55; a1 = 8'hAA; b1 = 8'h55; sel0 = 2'b10; sel1 = 2'b10;
    vectors++;
    if ({busy, done0, done1, alu_a, alu_b, alu_sel} !== {3'b100, a, b, sel}) begin
      miscompares++;
      $display("FAIL single_exec got %h want %h", {busy, done0, done1, alu_a, alu_b, alu_sel}, {3'b100, a, b, sel});
    end
    tick();
    vectors++;
    if ({done0, done1, busy, result, zero} !== {~who, who, 1'b1, exp_r, exp_z}) begin
      miscompares++;
      $display("FAIL single_done got %h want %h", {done0, done1, busy, result, zero}, {~who, who, 1'b1, exp_r, exp_z});
    end
    tick();
    vectors++;
    if ({done0, done1, busy, result, zero} !== {3'b000, exp_r, exp_z}) begin
      miscompares++;
      $display("FAIL single_hold got %h want %h", {done0, done1, busy, result, zero}, {3'b000, exp_r, exp_z});
    end
    exp_last = who;
  endtask

  // Both requesters held for n operations; expected winner per operation from a bench-side model.
  task automatic test_contend(input int n);
    logic w;
    logic [7:0] er;
    logic ez;
    req0 = 1; a0 = 8'h10; b0 = 8'h10; sel0 = 2'b01;
    req1 = 1; a1 = 8'hF0; b1 = 8'h33; sel1 = 2'b10;
    for (int k = 0; k < n; k++) begin
`ifdef ALU_ARB_PRIO_EN
      w = 1'b0;
`else
      w = ~exp_last;
`endif
      er = w ? 8'h0F : 8'h00;
      ez = ~w;
      tick();
      vectors++;
      if ({busy, alu_sel} !== {1'b1, (w ? 2'b10 : 2'b01)}) begin
        miscompares++;
        $display("FAIL contend_grant op %0d got %h want %h", k, {busy, alu_sel}, {1'b1, (w ? 2'b10 : 2'b01)});
      end
      tick();
      vectors++;
      if ({done0, done1, result, zero} !== {~w, w, er, ez}) begin
        miscompares++;
        $display("FAIL contend_done op %0d got %h want %h", k, {done0, done1, result, zero}, {~w, w, er, ez});
      end
      tick();
      vectors++;
      if ({done0, done1, busy} !== 3'b000) begin
        miscompares++;
        $display("FAIL contend_idle op %0d got %b want 000", k, {done0, done1, busy});
      end
      exp_last = w;
    end
    req0 = 0; req1 = 0;
  endtask

  task automatic test_reset_mid_exec();
    req0 = 1; a0 = 8'h21; b0 = 8'h01; sel0 = 2'b00;
    tick();
    req0 = 0;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({alu_a, alu_b, alu_sel, result, zero, done0, done1, busy} !== 29'd0) begin
      miscompares++;
      $display("FAIL async_reset got %h want 0", {alu_a, alu_b, alu_sel, result, zero, done0, done1, busy});
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++;
      if ({done0, done1, busy} !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_no_done cycle %0d got %b want 000", k, {done0, done1, busy});
      end
    end
    rst_n = 1'b1;
    exp_last = 1'b1;
  endtask

  initial begin
    test_reset();
    test_contend(1);                                      // first tie after reset goes to req0
    test_single(1'b0, 8'h05, 8'h03, 2'b00, 8'h08, 1'b0);
    test_single(1'b1, 8'hFF, 8'h01, 2'b00, 8'h00, 1'b1);
    test_contend(3);
    test_contend(4);
    test_single(1'b1, 8'h3C, 8'h0A, 2'b11, 8'h46, 1'b0);
    test_single(1'b0, 8'h01, 8'h02, 2'b01, 8'hFF, 1'b0);
    test_reset_mid_exec();
    test_single(1'b0, 8'h07, 8'h02, 2'b01, 8'h05, 1'b0);
    test_contend(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
